icache_mshr_ctrl: RTL and testbench

- Non-blocking instruction-cache controller; successor to the single-miss icache front end.
- Sits between fetch_stage, the icache data/tag array and the memory bus.
- Serves LANES fetch addresses per cycle and tracks up to NUM_MSHR outstanding line misses by memory tag, with duplicate-miss merging.
- Adds bypass of returning fill data, optional next-line prefetch, and flush.

---
 rtl/icache_mshr_ctrl.sv | 113 +++++++++++
 tb/tb_icache_mshr_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_mshr_ctrl.sv
// icache_mshr_ctrl: non-blocking icache front end with MSHR miss tracking, fill bypass and next-line prefetch
module icache_mshr_ctrl #(
  parameter int LANES = 3,
  parameter int NUM_MSHR = 4,
  parameter int IDX_W = 5,
  parameter int CTAG_W = 8,
  parameter int MTAG_W = 4,
  parameter int XLEN = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic prefetch_en,
  input  logic [MTAG_W-1:0] Imem2proc_response,
  input  logic [63:0] Imem2proc_data,
  input  logic [MTAG_W-1:0] Imem2proc_tag,
  input  logic [LANES-1:0][XLEN-1:0] proc2Icache_addr,
  input  logic [LANES-1:0][63:0] cachemem_data,
  input  logic [LANES-1:0] cachemem_valid,
  output logic [1:0] proc2Imem_command,
  output logic [XLEN-1:0] proc2Imem_addr,
  output logic [LANES-1:0][31:0] Icache_data_out,
  output logic [LANES-1:0] Icache_valid_out,
  output logic [LANES-1:0][IDX_W-1:0] rd_index,
  output logic [LANES-1:0][CTAG_W-1:0] rd_tag,
  output logic wr_en,
  output logic [IDX_W-1:0] wr_index,
  output logic [CTAG_W-1:0] wr_tag,
  output logic [63:0] wr_data,
  output logic mshr_full,
  output logic miss_pending
);
  localparam int LW = XLEN - 3;
  localparam int AW = $clog2(NUM_MSHR);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  logic [NUM_MSHR-1:0] valid, fill_vec;
  logic [NUM_MSHR-1:0][LW-1:0] line_q;
  logic [NUM_MSHR-1:0][MTAG_W-1:0] mtag_q;
  logic [LANES-1:0][LW-1:0] lane_line;
  logic [LANES-1:0] lane_busy, bypass;
  logic [LW-1:0] fill_line, dem_line, pf_line, pf_ptr, req_line;
  logic fill_hit, dem_ok, pf_ok, pf_busy, pf_done, issue, accept;
  logic [AW-1:0] alloc_idx;
  genvar i;
  for (i = 0; i < LANES; i++) begin : g_lane
    logic [63:0] src;
    assign lane_line[i] = proc2Icache_addr[i][XLEN-1:3];
    assign rd_index[i] = proc2Icache_addr[i][3+IDX_W-1:3];
    assign rd_tag[i] = proc2Icache_addr[i][3+IDX_W+CTAG_W-1:3+IDX_W];
    assign bypass[i] = fill_hit && !cachemem_valid[i] && lane_line[i] == fill_line;
    assign src = bypass[i] ? Imem2proc_data : cachemem_data[i];
    assign Icache_data_out[i] = proc2Icache_addr[i][2] ? src[63:32] : src[31:0];
    assign Icache_valid_out[i] = cachemem_valid[i] | bypass[i];
  end
  // returning data is ignored while in reset so stale tags never write the array
  always_comb begin
    fill_vec = '0;
    fill_line = '0;
    for (int m = 0; m < NUM_MSHR; m++) begin
      fill_vec[m] = !reset && valid[m] && Imem2proc_tag != '0 && mtag_q[m] == Imem2proc_tag;
      fill_line = fill_vec[m] ? line_q[m] : fill_line;
    end
  end
  assign fill_hit = |fill_vec;
  assign pf_line = pf_ptr + 1'b1;
  // ascending scan lets the highest (oldest) missing lane win; merged lines are already busy
  always_comb begin
    lane_busy = '0;
    pf_busy = 1'b0;
    dem_ok = 1'b0;
    dem_line = '0;
    for (int m = 0; m < NUM_MSHR; m++) begin
      pf_busy = pf_busy | (valid[m] && line_q[m] == pf_line);
      for (int l = 0; l < LANES; l++) lane_busy[l] = lane_busy[l] | (valid[m] && line_q[m] == lane_line[l]);
    end
    for (int l = 0; l < LANES; l++) begin
      dem_line = (!cachemem_valid[l] && !lane_busy[l]) ? lane_line[l] : dem_line;
      dem_ok = dem_ok | (!cachemem_valid[l] && !lane_busy[l]);
    end
  end
  always_comb begin
    alloc_idx = '0;
    for (int m = NUM_MSHR - 1; m >= 0; m--) alloc_idx = valid[m] ? alloc_idx : AW'(m);
  end
  assign pf_ok = !dem_ok && prefetch_en && !pf_done && !pf_busy;
  assign req_line = dem_ok ? dem_line : pf_line;
  assign mshr_full = &valid;
  assign miss_pending = |valid;
  assign issue = (dem_ok || pf_ok) && !mshr_full && !flush && !reset;
  assign accept = issue && Imem2proc_response != '0;
  assign proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr = {issue ? req_line : lane_line[LANES-1], 3'b0};
  assign wr_en = fill_hit;
  assign wr_index = fill_line[IDX_W-1:0];
  assign wr_tag = fill_line[IDX_W+CTAG_W-1:IDX_W];
  assign wr_data = Imem2proc_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      pf_ptr <= '0;
      pf_done <= 1'b1;
    end else begin
      valid <= (flush ? '0 : valid & ~fill_vec) | (accept ? NUM_MSHR'(1) << alloc_idx : '0);
      if (accept) begin
        line_q[alloc_idx] <= req_line;
        mtag_q[alloc_idx] <= Imem2proc_response;
        pf_ptr <= dem_ok ? req_line : pf_ptr;
        pf_done <= !dem_ok;
      end
    end
  end
endmodule

// File: tb/tb_icache_mshr_ctrl.sv
// tb_icache_mshr_ctrl: directed and randomized checks of icache_mshr_ctrl against a tag-indexed reference model
module tb_icache_mshr_ctrl;
  logic clock = 1'b0;
  logic reset, flush, prefetch_en;
  logic [3:0] Imem2proc_response, Imem2proc_tag;
  logic [63:0] Imem2proc_data;
  logic [2:0][31:0] proc2Icache_addr;
  logic [2:0][63:0] cachemem_data;
  logic [2:0] cachemem_valid;
  logic [1:0] proc2Imem_command;
  logic [31:0] proc2Imem_addr;
  logic [2:0][31:0] Icache_data_out;
  logic [2:0] Icache_valid_out;
  logic [2:0][4:0] rd_index;
  logic [2:0][7:0] rd_tag;
  logic wr_en;
  logic [4:0] wr_index;
  logic [7:0] wr_tag;
  logic [63:0] wr_data;
  logic mshr_full, miss_pending;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  bit tv [16];
  logic [28:0] tl [16];
  logic [28:0] mp_ptr = '0;
  bit mp_done = 1'b1;
  bit e_fill, e_dem, e_pf, e_issue;
  logic [28:0] e_fline, e_line;
  int e_cnt;

  icache_mshr_ctrl dut (
    .clock(clock), .reset(reset), .flush(flush), .prefetch_en(prefetch_en),
    .Imem2proc_response(Imem2proc_response), .Imem2proc_data(Imem2proc_data),
    .Imem2proc_tag(Imem2proc_tag), .proc2Icache_addr(proc2Icache_addr),
    .cachemem_data(cachemem_data), .cachemem_valid(cachemem_valid),
    .proc2Imem_command(proc2Imem_command), .proc2Imem_addr(proc2Imem_addr),
    .Icache_data_out(Icache_data_out), .Icache_valid_out(Icache_valid_out),
    .rd_index(rd_index), .rd_tag(rd_tag), .wr_en(wr_en), .wr_index(wr_index),
    .wr_tag(wr_tag), .wr_data(wr_data), .mshr_full(mshr_full), .miss_pending(miss_pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(input logic [28:0] ln);
    for (int t = 1; t < 16; t++) if (tv[t] && tl[t] == ln) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] free_tag();
    logic [3:0] t;
    do t = 4'($urandom_range(1, 15)); while (tv[t]);
    return t;
  endfunction

  function automatic logic [3:0] live_tag();
    logic [3:0] q[$];
    for (int t = 1; t < 16; t++) if (tv[t]) q.push_back(4'(t));
    return q.size() == 0 ? 4'h0 : q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic model_eval();
    e_cnt = 0;
    for (int t = 1; t < 16; t++) if (tv[t]) e_cnt++;
    e_fill = !reset && Imem2proc_tag != 4'h0 && tv[Imem2proc_tag];
    e_fline = tl[Imem2proc_tag];
    e_dem = 1'b0;
    e_line = mp_ptr + 29'd1;
    for (int l = 2; l >= 0 && !e_dem; l--)
      if (!cachemem_valid[l] && !pending(proc2Icache_addr[l][31:3])) begin
        e_dem = 1'b1;
        e_line = proc2Icache_addr[l][31:3];
      end
    e_pf = !e_dem && prefetch_en && !mp_done && !pending(mp_ptr + 29'd1);
    e_issue = (e_dem || e_pf) && e_cnt < 4 && !flush && !reset;
  endtask

  task automatic check_all();
    logic byp;
    logic [63:0] src;
    chk("cmd", 64'(proc2Imem_command), e_issue ? 64'd1 : 64'd0);
    chk("bus_addr", 64'(proc2Imem_addr), e_issue ? 64'({e_line, 3'b0}) : 64'({proc2Icache_addr[2][31:3], 3'b0}));
    chk("wr_en", 64'(wr_en), 64'(e_fill));
    if (e_fill) begin
      chk("wr_index", 64'(wr_index), 64'(e_fline[4:0]));
      chk("wr_tag", 64'(wr_tag), 64'(e_fline[12:5]));
      chk("wr_data", wr_data, Imem2proc_data);
    end
    chk("mshr_full", 64'(mshr_full), 64'(e_cnt == 4));
    chk("miss_pending", 64'(miss_pending), 64'(e_cnt != 0));
    for (int l = 0; l < 3; l++) begin
      chk("rd_index", 64'(rd_index[l]), 64'(proc2Icache_addr[l][7:3]));
      chk("rd_tag", 64'(rd_tag[l]), 64'(proc2Icache_addr[l][15:8]));
      if (!reset) begin
        byp = e_fill && !cachemem_valid[l] && proc2Icache_addr[l][31:3] == e_fline;
        src = byp ? Imem2proc_data : cachemem_data[l];
        chk("lane_valid", 64'(Icache_valid_out[l]), 64'(cachemem_valid[l] | byp));
        chk("lane_data", 64'(Icache_data_out[l]), 64'(proc2Icache_addr[l][2] ? src[63:32] : src[31:0]));
      end
    end
  endtask

  task automatic model_update();
    if (reset) begin
      tv = '{default: 1'b0};
      mp_ptr = '0;
      mp_done = 1'b1;
    end else begin
      if (e_fill) tv[Imem2proc_tag] = 1'b0;
      if (flush) tv = '{default: 1'b0};
      if (e_issue && Imem2proc_response != 4'h0) begin
        tv[Imem2proc_response] = 1'b1;
        tl[Imem2proc_response] = e_line;
        if (e_dem) begin
          mp_ptr = e_line;
          mp_done = 1'b0;
        end else mp_done = 1'b1;
      end
    end
  endtask

  task automatic pre();
    #1;
    model_eval();
    check_all();
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic step();
    pre();
    tick();
  endtask

  task automatic lanes(input logic [31:0] a2, input logic [31:0] a1, input logic [31:0] a0, input logic [2:0] cv);
    proc2Icache_addr = {a2, a1, a0};
    cachemem_valid = cv;
    for (int l = 0; l < 3; l++) cachemem_data[l] = {$urandom, $urandom};
  endtask

  task automatic mem(input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] d);
    Imem2proc_response = resp;
    Imem2proc_tag = tag;
    Imem2proc_data = d;
  endtask

  task automatic drain();
    lanes(32'h10, 32'h18, 32'h20, 3'b111);
    mem(0, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1;
    flush = 1'b0;
    prefetch_en = 1'b0;
    lanes(32'h10, 32'h18, 32'h20, 3'b111);
    mem(0, 0, 0);
    tick();
    mem(4'h3, 4'h1, 64'h1234);
    step();
    reset = 1'b0;
    mem(0, 0, 0);
    pre();
    chk("rst_full", 64'(mshr_full), 64'd0);
    chk("rst_pending", 64'(miss_pending), 64'd0);
    tick();
    // single miss, fill returns two cycles after acceptance
    lanes(32'h0108, 32'h10, 32'h18, 3'b011);
    mem(3, 0, 0);
    pre();
    chk("sm_cmd", 64'(proc2Imem_command), 64'd1);
    chk("sm_addr", 64'(proc2Imem_addr), 64'h108);
    tick();
    mem(0, 0, 0);
    pre();
    chk("sm_wait_cmd", 64'(proc2Imem_command), 64'd0);
    tick();
    mem(0, 3, 64'hAAAA_BBBB_CCCC_DDDD);
    pre();
    chk("sm_wr_en", 64'(wr_en), 64'd1);
    chk("sm_wr_index", 64'(wr_index), 64'h01);
    chk("sm_wr_tag", 64'(wr_tag), 64'h01);
    chk("sm_bypass_data", 64'(Icache_data_out[2]), 64'hCCCC_DDDD);
    chk("sm_bypass_valid", 64'(Icache_valid_out[2]), 64'd1);
    tick();
    lanes(32'h10, 32'h18, 32'h20, 3'b111);
    mem(0, 0, 0);
    pre();
    chk("sm_freed", 64'(miss_pending), 64'd0);
    tick();
    // merge of duplicate lines across lanes
    lanes(32'h0200, 32'h0204, 32'h0300, 3'b000);
    mem(1, 0, 0);
    pre();
    chk("mg_first", 64'(proc2Imem_addr), 64'h200);
    tick();
    mem(2, 0, 0);
    pre();
    chk("mg_second", 64'(proc2Imem_addr), 64'h300);
    tick();
    mem(0, 0, 0);
    pre();
    chk("mg_idle", 64'(proc2Imem_command), 64'd0);
    tick();
    drain();
    // fill all entries, then free one with a fill
    for (int k = 0; k < 4; k++) begin
      lanes(32'h0500 + 32'(k) * 8, 32'h10, 32'h18, 3'b011);
      mem(4'(k + 1), 0, 0);
      step();
    end
    lanes(32'h0600, 32'h10, 32'h18, 3'b011);
    mem(5, 0, 0);
    pre();
    chk("full_flag", 64'(mshr_full), 64'd1);
    chk("full_no_cmd", 64'(proc2Imem_command), 64'd0);
    tick();
    mem(5, 2, 64'h5555);
    pre();
    chk("full_fill_wr", 64'(wr_en), 64'd1);
    chk("full_fill_no_cmd", 64'(proc2Imem_command), 64'd0);
    tick();
    mem(5, 0, 0);
    pre();
    chk("full_reissue", 64'(proc2Imem_addr), 64'h600);
    tick();
    drain();
    // rejected requests are retried with the same address
    lanes(32'h0700, 32'h10, 32'h18, 3'b011);
    for (int k = 0; k < 3; k++) begin
      mem(0, 0, 0);
      pre();
      chk("rj_cmd", 64'(proc2Imem_command), 64'd1);
      chk("rj_addr", 64'(proc2Imem_addr), 64'h700);
      tick();
    end
    mem(5, 0, 0);
    step();
    mem(0, 0, 0);
    pre();
    chk("rj_alloc", 64'(miss_pending), 64'd1);
    tick();
    drain();
    // flush discards outstanding tags
    lanes(32'h0800, 32'h0900, 32'h18, 3'b001);
    mem(1, 0, 0);
    step();
    mem(2, 0, 0);
    step();
    drain();
    mem(0, 1, 64'h77);
    pre();
    chk("fl_stale_wr", 64'(wr_en), 64'd0);
    chk("fl_pending", 64'(miss_pending), 64'd0);
    tick();
    // next-line prefetch issued once
    prefetch_en = 1'b1;
    lanes(32'h0400, 32'h10, 32'h18, 3'b011);
    mem(6, 0, 0);
    step();
    lanes(32'h10, 32'h18, 32'h20, 3'b111);
    mem(7, 0, 0);
    pre();
    chk("pf_addr", 64'(proc2Imem_addr), 64'h408);
    tick();
    mem(8, 0, 0);
    pre();
    chk("pf_once", 64'(proc2Imem_command), 64'd0);
    tick();
    prefetch_en = 1'b0;
    drain();
    // reset mid-operation
    lanes(32'h0A00, 32'h10, 32'h18, 3'b011);
    mem(3, 0, 0);
    step();
    reset = 1'b1;
    mem(0, 0, 0);
    step();
    reset = 1'b0;
    lanes(32'h10, 32'h18, 32'h20, 3'b111);
    mem(0, 3, 64'h99);
    pre();
    chk("rs_stale_wr", 64'(wr_en), 64'd0);
    tick();
    for (int c = 0; c < 600; c++) begin
      for (int l = 0; l < 3; l++) begin
        proc2Icache_addr[l] = 32'h1000 + 32'($urandom_range(0, 7)) * 8 + ($urandom_range(0, 1) != 0 ? 32'h4 : 32'h0);
        cachemem_data[l] = {$urandom, $urandom};
      end
      cachemem_valid = 3'($urandom);
      Imem2proc_response = $urandom_range(0, 1) != 0 ? free_tag() : 4'h0;
      r = $urandom_range(0, 9);
      Imem2proc_tag = r < 4 ? live_tag() : (r == 4 ? 4'($urandom) : 4'h0);
      Imem2proc_data = {$urandom, $urandom};
      flush = $urandom_range(0, 31) == 0;
      reset = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 9) == 0) prefetch_en = ~prefetch_en;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
